// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter (state encodings, frame sizes).
// Parity build option: define UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_STOP    = 3'd3,
    s_CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
    , s_PARITY = 3'd5
`endif
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the UART shifter; drops writes while full and
// flags each dropped write with a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic [FIFO_AW:0] level_o,
  output logic             ready_o,
  output logic             overflow_o
);

  localparam int              DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               full, empty, do_wr, do_rd;

  // Fullness comes from the registered level, so a same-cycle pop never frees a slot.
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign do_wr = wr_en_i && !full;
  assign do_rd = rd_en_i && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = wr_en_i && full;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; pointers and level alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign ready_o    = !full;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: FIFO plus 8N1 frame shifter (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Tx_DV,
  input  logic [7:0]       i_Tx_Byte,
  output logic             o_Tx_Ready,
  output logic             o_Tx_Overflow,
  output logic             o_Tx_Serial,
  output logic             o_Tx_Active,
  output logic             o_Tx_Done,
  output logic [FIFO_AW:0] o_Fifo_Level
);

  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic [FIFO_AW:0] fifo_level;

  uart_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i      (i_Clock),
    .rst_i      (i_Reset),
    .wr_en_i    (i_Tx_DV),
    .wr_data_i  (i_Tx_Byte),
    .rd_en_i    (fifo_pop),
    .rd_data_o  (fifo_head),
    .level_o    (fifo_level),
    .ready_o    (o_Tx_Ready),
    .overflow_o (o_Tx_Overflow)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      s_IDLE: begin
        serial_d  = 1'b1;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (fifo_level != '0) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          active_d = 1'b1;
          state_d  = s_START;
        end
      end

      s_START: begin
        serial_d = 1'b0;
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = s_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      s_DATA: begin
        serial_d = shift_q[bit_idx_q];
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = s_PARITY;
`else
            state_d   = s_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      s_PARITY: begin
        serial_d = ^shift_q;
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          state_d   = s_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
`endif

      s_STOP: begin
        serial_d = 1'b1;
        // Done and Active switch on the final stop-bit cycle; CLEANUP then drops Done.
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          active_d  = 1'b0;
          state_d   = s_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      s_CLEANUP: begin
        state_d = s_IDLE;
      end

      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= s_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Level = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl: stimulus queues expected bytes, a serial
// monitor decodes every frame on o_Tx_Serial and compares against the queue.
module tb_uart_tx_fifo_ctrl;

  localparam int C   = 4;
  localparam int AW  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_SMP = FRAME_BITS * C;
  localparam int GAP       = C + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv  = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          o_Tx_Ready, o_Tx_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [AW:0]   o_Fifo_Level;

  uart_tx_fifo_ctrl #(
    .CLKS_PER_BIT (C),
    .FIFO_AW      (AW)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Tx_DV       (dv),
    .i_Tx_Byte     (tx_byte),
    .o_Tx_Ready    (o_Tx_Ready),
    .o_Tx_Overflow (o_Tx_Overflow),
    .o_Tx_Serial   (o_Tx_Serial),
    .o_Tx_Active   (o_Tx_Active),
    .o_Tx_Done     (o_Tx_Done),
    .o_Fifo_Level  (o_Fifo_Level)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;   // expected idle-high run before this frame, 0 = don't care
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, fails = 0;
  int   done_cnt = 0, active_cnt = 0, low_cnt = 0, ovf_cnt = 0;

  // Monitor state
  logic [FRAME_SMP-1:0] smp;
  bit   collecting = 1'b0, have_prev = 1'b0, prev_done = 1'b0;
  int   pos = 0, high_run = 0, gap_meas = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input logic [FRAME_SMP-1:0] s, input int gap);
    logic [FRAME_BITS-1:0] bits;
    bit   steady;
    exp_t e;
    steady = 1'b1;
    for (int j = 0; j < FRAME_BITS; j++) begin
      bits[j] = s[j*C];
      for (int k = 1; k < C; k++)
        if (s[j*C+k] !== bits[j]) steady = 1'b0;
    end
    check("bit_width", 32'(steady), 32'd1);
    check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
    checks++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_frame actual=%0h expected=none t=%0t", bits[8:1], $time);
    end else begin
      e = sb_q.pop_front();
      check("frame_data", 32'(bits[8:1]), 32'(e.data));
      if (e.gap != 0) check("interframe_gap", 32'(gap), 32'(e.gap));
`ifdef UART_TX_PARITY_EN
      check("parity_bit", 32'(bits[9]), 32'(e.par));
`endif
    end
  endtask

  // Serial monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (o_Tx_Done) begin
        done_cnt++;
        check("done_pulse_width", 32'(prev_done), 32'd0);
      end
      prev_done  = o_Tx_Done;
      active_cnt += int'(o_Tx_Active);
      low_cnt    += int'(!o_Tx_Serial);
      ovf_cnt    += int'(o_Tx_Overflow);
      if (rst) begin
        collecting = 1'b0;
        have_prev  = 1'b0;
        high_run   = 0;
      end else if (!collecting) begin
        if (!o_Tx_Serial) begin
          collecting = 1'b1;
          smp[0]     = 1'b0;
          pos        = 1;
          gap_meas   = have_prev ? C + high_run : -1;
        end else begin
          high_run++;
        end
      end else begin
        smp[pos] = o_Tx_Serial;
        pos++;
        if (pos == FRAME_SMP) begin
          collecting = 1'b0;
          have_prev  = 1'b1;
          high_run   = 0;
          check_frame(smp, gap_meas);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    e.par  = ^d;
    sb_q.push_back(e);
  endtask

  task automatic write_byte(input logic [7:0] b);
    dv      = 1'b1;
    tx_byte = b;
    step();
    dv      = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && !o_Tx_Active && o_Fifo_Level == '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (4) step();
  endtask

  initial begin : stimulus
    int a0, d0, l0, o0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial", 32'(o_Tx_Serial), 32'd1);
    check("rst_active", 32'(o_Tx_Active), 32'd0);
    check("rst_done", 32'(o_Tx_Done), 32'd0);
    check("rst_overflow", 32'(o_Tx_Overflow), 32'd0);
    check("rst_level", 32'(o_Fifo_Level), 32'd0);
    check("rst_ready", 32'(o_Tx_Ready), 32'd1);
    step();
    rst = 1'b0;

    // Idle 50 cycles
    l0 = low_cnt;
    d0 = done_cnt;
    repeat (50) step();
    check("idle_serial", 32'(o_Tx_Serial), 32'd1);
    check("idle_ready", 32'(o_Tx_Ready), 32'd1);
    check("idle_level", 32'(o_Fifo_Level), 32'd0);
    check("idle_no_low", 32'(low_cnt - l0), 32'd0);
    check("idle_no_done", 32'(done_cnt - d0), 32'd0);

    // Single byte 0xA5: latency, active length, one done pulse
    a0 = active_cnt;
    d0 = done_cnt;
    push_exp(8'hA5, 0);
    write_byte(8'hA5);
    check("a5_edgeN_serial", 32'(o_Tx_Serial), 32'd1);
    check("a5_edgeN_level", 32'(o_Fifo_Level), 32'd1);
    step();
    check("a5_edgeN1_serial", 32'(o_Tx_Serial), 32'd1);
    check("a5_edgeN1_active", 32'(o_Tx_Active), 32'd1);
    check("a5_edgeN1_level", 32'(o_Fifo_Level), 32'd0);
    step();
    check("a5_start_latency", 32'(o_Tx_Serial), 32'd0);
    wait_drain(200);
    check("a5_active_cycles", 32'(active_cnt - a0), 32'(FRAME_SMP));
    check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Three consecutive writes: ordering, gaps, level trace
    push_exp(8'h00, 0);
    push_exp(8'hFF, GAP);
    push_exp(8'h3C, GAP);
    write_byte(8'h00);
    check("b3_level_w0", 32'(o_Fifo_Level), 32'd1);
    write_byte(8'hFF);
    check("b3_level_w1", 32'(o_Fifo_Level), 32'd1);
    write_byte(8'h3C);
    check("b3_level_w2", 32'(o_Fifo_Level), 32'd2);
    wait_drain(400);
    check("b3_level_drained", 32'(o_Fifo_Level), 32'd0);

    // 17 writes while idle fill the FIFO exactly; one more is dropped
    for (int i = 0; i < 17; i++) begin
      push_exp(8'(i * 13 + 1), (i == 0) ? 0 : GAP);
      write_byte(8'(i * 13 + 1));
    end
    check("full_level", 32'(o_Fifo_Level), 32'd16);
    check("full_ready", 32'(o_Tx_Ready), 32'd0);
    o0 = ovf_cnt;
    write_byte(8'hEE);
    check("ovf_pulse", 32'(o_Tx_Overflow), 32'd1);
    check("ovf_level", 32'(o_Fifo_Level), 32'd16);
    step();
    check("ovf_pulse_end", 32'(o_Tx_Overflow), 32'd0);
    wait_drain(1500);
    check("ovf_pulse_count", 32'(ovf_cnt - o0), 32'd1);

    // Reset during data bit 3 of 0x55 with two bytes queued
    write_byte(8'h55);
    write_byte(8'h11);
    write_byte(8'h22);
    check("rst_mid_level", 32'(o_Fifo_Level), 32'd2);
    repeat (15) step();
    check("rst_mid_bit2", 32'(o_Tx_Serial), 32'd1);
    step();
    check("rst_mid_bit3", 32'(o_Tx_Serial), 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    l0 = low_cnt;
    check("rst_mid_serial", 32'(o_Tx_Serial), 32'd1);
    check("rst_mid_level0", 32'(o_Fifo_Level), 32'd0);
    check("rst_mid_active", 32'(o_Tx_Active), 32'd0);
    repeat (100) step();
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_no_frames", 32'(low_cnt - l0), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones, 0x03 has two
    begin
      exp_t e;
      a0 = active_cnt;
      e.data = 8'h07; e.gap = 0; e.par = 1'b1;
      sb_q.push_back(e);
      write_byte(8'h07);
      wait_drain(200);
      e.data = 8'h03; e.gap = 0; e.par = 1'b0;
      sb_q.push_back(e);
      write_byte(8'h03);
      wait_drain(200);
      check("parity_active_cycles", 32'(active_cnt - a0), 32'd88);
    end
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
